tvm_linebuff_window_ctrl: RTL and testbench

Read-side sequencer for a `tvm_buffer` configured as a line buffer (depth ≥ (K-1)·W+K+1, read window (K-1)·W+K, advance 1) in the KxK convolution datapath. It drives the buffer's read port: it walks the KxK tap addresses of each window position, slides the window one pixel per position and skips positions that straddle a row edge. At frame end it drains the leftover pixels. It re-emits the returned pixels as an annotated tap stream, with window coordinates and first/last markers, for the MAC array.

---
 rtl/tvm_linebuff_pkg.sv | 34 +++
 rtl/tvm_mod_counter.sv | 37 +++
 rtl/tvm_linebuff_window_ctrl.sv | 153 +++++++++++++++
 tb/tb_tvm_linebuff_window_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tvm_linebuff_pkg.sv
// Shared types and sizing helpers for the line-buffer window read sequencer.
package tvm_linebuff_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_TAPS,
      ST_SKIP,
      ST_DRAIN,
      ST_DONE
   } state_e;

   // Geometry of the default 8-pixel-wide, 3x3 configuration.
   localparam int DEF_W     = 8;
   localparam int DEF_K     = 3;
   localparam int KK        = DEF_K * DEF_K;
   localparam int RD_WINDOW = (DEF_K - 1) * DEF_W + DEF_K;
   localparam int SKIP_N    = DEF_K - 1;
   localparam int DRAIN_N   = RD_WINDOW - 1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < v) r = r + 1;
      end
      return r;
   endfunction

   // Counter register width for a given modulus, never narrower than one bit.
   function automatic int cnt_width(input int m);
      return (m <= 2) ? 1 : clog2(m);
   endfunction

endpackage

// File: rtl/tvm_mod_counter.sv
// Modulo-MOD up-counter with synchronous clear and a wrap pulse on the terminal increment.
module tvm_mod_counter #(
   parameter int MOD   = 4,
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_i,
   input  logic             en_i,
   output logic [WIDTH-1:0] cnt_o,
   output logic             wrap_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   assign wrap_o = en_i && (cnt_q == WIDTH'(MOD - 1));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || wrap_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/tvm_linebuff_window_ctrl.sv
// Line-buffer read sequencer: walks KxK taps per window, skips row-edge positions,
// drains the buffer at frame end and emits an annotated tap stream.
module tvm_linebuff_window_ctrl
   import tvm_linebuff_pkg::*;
#(
   parameter int IMAGE_WIDTH   = 8,
   parameter int IMAGE_HEIGHT  = 8,
   parameter int KERNEL_WIDTH  = 3,
   parameter int DATA_WIDTH    = 8,
   parameter int RD_ADDR_WIDTH = 5,
   parameter int COORD_WIDTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   output logic                     busy,
   output logic                     done,
   input  logic                     buf_read_valid,
   output logic                     buf_read_ready,
   output logic [RD_ADDR_WIDTH-1:0] buf_read_addr,
   output logic                     buf_read_advance,
   input  logic [DATA_WIDTH-1:0]    buf_read_data,
   output logic                     win_valid,
   output logic [DATA_WIDTH-1:0]    win_data,
   output logic                     win_first,
   output logic                     win_last,
   output logic [COORD_WIDTH-1:0]   win_x,
   output logic [COORD_WIDTH-1:0]   win_y
);

   localparam int W       = IMAGE_WIDTH;
   localparam int H       = IMAGE_HEIGHT;
   localparam int K       = KERNEL_WIDTH;
   localparam int NX      = W - K + 1;
   localparam int NY      = H - K + 1;
   localparam int L_SKIP  = K - 1;
   localparam int L_DRAIN = (K - 1) * W + K - 1;
   localparam int TW      = cnt_width(K);
   localparam int XW      = cnt_width(NX);
   localparam int YW      = cnt_width(NY);
   localparam int AUXW    = cnt_width(L_DRAIN);

   if (K < 2) begin : g_err_k
      $error("KERNEL_WIDTH must be at least 2");
   end
   if ((W < K) || (H < K)) begin : g_err_dim
      $error("IMAGE_WIDTH and IMAGE_HEIGHT must be at least KERNEL_WIDTH");
   end
   if (clog2((K - 1) * W + K) > RD_ADDR_WIDTH) begin : g_err_addr
      $error("RD_ADDR_WIDTH too narrow for the read window");
   end
   if (clog2((W > H) ? W : H) > COORD_WIDTH) begin : g_err_coord
      $error("COORD_WIDTH too narrow for the image size");
   end

   state_e state_q;
   state_e state_d;

   logic          active;
   logic          hs;
   logic          tap_hs;
   logic          start_acc;
   logic [TW-1:0] tap_c;
   logic [TW-1:0] tap_r;
   logic [XW-1:0] x_cnt;
   logic [YW-1:0] y_cnt;
   logic [AUXW-1:0] aux_cnt;
   logic          c_wrap;
   logic          r_wrap;
   logic          x_wrap;
   logic          y_wrap;
   logic          aux_wrap;
   logic          skip_done;
   logic          last_tap;

   assign active    = (state_q == ST_TAPS) || (state_q == ST_SKIP) || (state_q == ST_DRAIN);
   assign hs        = active && buf_read_valid;
   assign tap_hs    = hs && (state_q == ST_TAPS);
   assign start_acc = start && (state_q == ST_IDLE);
   assign last_tap  = (tap_r == TW'(K - 1)) && (tap_c == TW'(K - 1));
   assign skip_done = hs && (state_q == ST_SKIP) && (aux_cnt == AUXW'(L_SKIP - 1));

   // r_wrap marks the final tap of a window; the row counter advances at the
   // end of each row so x_wrap together with y_wrap flags the frame's last window.
   tvm_mod_counter #(.MOD(K), .WIDTH(TW)) u_tap_c (
      .clk(clk), .rst(rst), .clr_i(start_acc), .en_i(tap_hs), .cnt_o(tap_c), .wrap_o(c_wrap)
   );
   tvm_mod_counter #(.MOD(K), .WIDTH(TW)) u_tap_r (
      .clk(clk), .rst(rst), .clr_i(start_acc), .en_i(c_wrap), .cnt_o(tap_r), .wrap_o(r_wrap)
   );
   tvm_mod_counter #(.MOD(NX), .WIDTH(XW)) u_win_x (
      .clk(clk), .rst(rst), .clr_i(start_acc), .en_i(r_wrap), .cnt_o(x_cnt), .wrap_o(x_wrap)
   );
   tvm_mod_counter #(.MOD(NY), .WIDTH(YW)) u_win_y (
      .clk(clk), .rst(rst), .clr_i(start_acc), .en_i(x_wrap), .cnt_o(y_cnt), .wrap_o(y_wrap)
   );
   tvm_mod_counter #(.MOD(L_DRAIN), .WIDTH(AUXW)) u_aux (
      .clk(clk), .rst(rst), .clr_i(start_acc || skip_done),
      .en_i(hs && ((state_q == ST_SKIP) || (state_q == ST_DRAIN))),
      .cnt_o(aux_cnt), .wrap_o(aux_wrap)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_TAPS;
         ST_TAPS: begin
            if (y_wrap) state_d = ST_DRAIN;
            else if (x_wrap) state_d = ST_SKIP;
         end
         ST_SKIP:  if (skip_done) state_d = ST_TAPS;
         ST_DRAIN: if (aux_wrap && (state_q == ST_DRAIN)) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign buf_read_ready   = active;
   assign busy             = active;
   assign done             = (state_q == ST_DONE);
   assign buf_read_advance = (state_q == ST_TAPS) ? last_tap : active;
   assign buf_read_addr    = (state_q == ST_TAPS)
                           ? (RD_ADDR_WIDTH'(tap_r) * RD_ADDR_WIDTH'(W) + RD_ADDR_WIDTH'(tap_c))
                           : '0;
   assign win_data         = buf_read_data;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         win_valid <= 1'b0;
         win_first <= 1'b0;
         win_last  <= 1'b0;
         win_x     <= '0;
         win_y     <= '0;
      end else begin
         win_valid <= tap_hs;
         if (tap_hs) begin
            win_first <= (tap_r == '0) && (tap_c == '0);
            win_last  <= last_tap;
            win_x     <= COORD_WIDTH'(x_cnt);
            win_y     <= COORD_WIDTH'(y_cnt);
         end
      end
   end

endmodule

// File: tb/tb_tvm_linebuff_window_ctrl.sv
// Scoreboard bench for tvm_linebuff_window_ctrl with a behavioural line-buffer model.
`timescale 1ns/1ps
module tb_tvm_linebuff_window_ctrl;

   localparam int W  = 8;
   localparam int H  = 8;
   localparam int K  = 3;
   localparam int DW = 8;
   localparam int AW = 5;
   localparam int CW = 4;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic          adv;
   } hs_t;

   typedef struct packed {
      logic [DW-1:0] data;
      logic          first;
      logic          last;
      logic [CW-1:0] x;
      logic [CW-1:0] y;
   } win_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          busy;
   logic          done;
   logic          buf_read_valid = 1'b0;
   logic          buf_read_ready;
   logic [AW-1:0] buf_read_addr;
   logic          buf_read_advance;
   logic [DW-1:0] buf_read_data;
   logic          win_valid;
   logic [DW-1:0] win_data;
   logic          win_first;
   logic          win_last;
   logic [CW-1:0] win_x;
   logic [CW-1:0] win_y;

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   hs_t  q_hs[$];
   win_t q_win[$];
   int   first_addr[$];
   int   n_hs, n_adv, n_win, n_done;
   bit   stall_en = 1'b0;
   int   pix_base;
   hs_t  e_hs;
   win_t e_win;
   logic [AW-1:0] st_addr;
   logic          st_adv;
   bit            st_pend = 1'b0;

   tvm_linebuff_window_ctrl #(
      .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .KERNEL_WIDTH(K),
      .DATA_WIDTH(DW), .RD_ADDR_WIDTH(AW), .COORD_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .buf_read_valid(buf_read_valid), .buf_read_ready(buf_read_ready),
      .buf_read_addr(buf_read_addr), .buf_read_advance(buf_read_advance),
      .buf_read_data(buf_read_data), .win_valid(win_valid), .win_data(win_data),
      .win_first(win_first), .win_last(win_last), .win_x(win_x), .win_y(win_y)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pix(input int i);
      logic [31:0] v;
      v = i * 37 + 11;
      return v[7:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Line-buffer model: pixel stream indexed from the oldest buffered pixel.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         pix_base      <= 0;
         buf_read_data <= '0;
      end else if (buf_read_ready && buf_read_valid) begin
         buf_read_data <= pix(pix_base + int'(buf_read_addr));
         if (buf_read_advance) pix_base <= pix_base + 1;
      end
   end

   always @(posedge clk) begin
      #1;
      buf_read_valid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: checks every handshake and every tap against the queued expectations.
   always @(negedge clk) begin
      if (rst) begin
         st_pend = 1'b0;
      end else begin
         if (st_pend && buf_read_ready) begin
            chk("stall_addr_hold", 32'(buf_read_addr), 32'(st_addr));
            chk("stall_adv_hold", 32'(buf_read_advance), 32'(st_adv));
         end
         st_pend = buf_read_ready && !buf_read_valid;
         st_addr = buf_read_addr;
         st_adv  = buf_read_advance;
         if (buf_read_ready && buf_read_valid) begin
            n_hs++;
            if (buf_read_advance) n_adv++;
            if (first_addr.size() < K * K) first_addr.push_back(int'(buf_read_addr));
            if (q_hs.size() == 0) begin
               chk("hs_unexpected", 32'd1, 32'd0);
            end else begin
               e_hs = q_hs.pop_front();
               chk("hs_addr_adv", 32'({buf_read_addr, buf_read_advance}), 32'(e_hs));
            end
         end
         if (win_valid) begin
            n_win++;
            if (q_win.size() == 0) begin
               chk("win_unexpected", 32'd1, 32'd0);
            end else begin
               e_win = q_win.pop_front();
               chk("win_tap", 32'({win_data, win_first, win_last, win_x, win_y}), 32'(e_win));
               if (win_last) $display("window x=%0d y=%0d taps checked", win_x, win_y);
            end
         end
         if (done) n_done++;
      end
   end

   task automatic build_frame(input int fb);
      hs_t  eh;
      win_t ew;
      int   n;
      for (int y = 0; y <= H - K; y++) begin
         for (int x = 0; x <= W - K; x++) begin
            for (int r = 0; r < K; r++) begin
               for (int c = 0; c < K; c++) begin
                  eh.addr  = AW'(r * W + c);
                  eh.adv   = (r == K - 1) && (c == K - 1);
                  q_hs.push_back(eh);
                  ew.data  = pix(fb + (y + r) * W + x + c);
                  ew.first = (r == 0) && (c == 0);
                  ew.last  = (r == K - 1) && (c == K - 1);
                  ew.x     = CW'(x);
                  ew.y     = CW'(y);
                  q_win.push_back(ew);
               end
            end
            if (x == W - K) begin
               n = (y == H - K) ? ((K - 1) * W + K - 1) : (K - 1);
               eh.addr = '0;
               eh.adv  = 1'b1;
               for (int i = 0; i < n; i++) q_hs.push_back(eh);
            end
         end
      end
   endtask

   task automatic clear_counts();
      n_hs = 0; n_adv = 0; n_win = 0; n_done = 0;
      first_addr.delete();
   endtask

   task automatic pulse_start(output int sc);
      @(posedge clk); #1;
      chk("busy_before_start", 32'(busy), 32'd0);
      start = 1'b1;
      sc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", 32'(busy), 32'd1);
      chk("ready_after_start", 32'(buf_read_ready), 32'd1);
   endtask

   task automatic wait_done(input int lim, output int dc);
      dc = -1;
      for (int i = 0; i < lim && dc < 0; i++) begin
         @(negedge clk);
         if (done) dc = cyc;
      end
      if (dc < 0) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_counts(input string tag);
      chk({tag, "_win_count"}, 32'(n_win), 32'd324);
      chk({tag, "_hs_count"}, 32'(n_hs), 32'd352);
      chk({tag, "_adv_count"}, 32'(n_adv), 32'd64);
      chk({tag, "_done_count"}, 32'(n_done), 32'd1);
      chk({tag, "_hs_queue_left"}, 32'(q_hs.size()), 32'd0);
      chk({tag, "_win_queue_left"}, 32'(q_win.size()), 32'd0);
      chk({tag, "_idle_ready"}, 32'(buf_read_ready), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(buf_read_ready), 32'd0);
      chk({tag, "_advance"}, 32'(buf_read_advance), 32'd0);
      chk({tag, "_addr"}, 32'(buf_read_addr), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_win_valid"}, 32'(win_valid), 32'd0);
      chk({tag, "_first"}, 32'(win_first), 32'd0);
      chk({tag, "_last"}, 32'(win_last), 32'd0);
      chk({tag, "_x"}, 32'(win_x), 32'd0);
      chk({tag, "_y"}, 32'(win_y), 32'd0);
   endtask

   initial begin
      int sc;
      int dc;
      int found;
      int exp_first[9];
      exp_first = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;
      clear_counts();

      // Frame 1: unstalled, full sweep plus first-window addresses and latency.
      build_frame(0);
      pulse_start(sc);
      wait_done(2000, dc);
      chk("f1_done_latency", 32'(dc - sc), 32'd353);
      repeat (3) @(negedge clk);
      check_counts("f1");
      chk("f1_first_addr_n", 32'(first_addr.size()), 32'd9);
      for (int i = 0; i < 9 && i < first_addr.size(); i++)
         chk("f1_first_window_addr", 32'(first_addr[i]), 32'(exp_first[i]));

      // Frame 2: random stalls, stray starts while busy and in the DONE cycle.
      clear_counts();
      stall_en = 1'b1;
      build_frame(64);
      pulse_start(sc);
      repeat (40) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(4000, dc);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      stall_en = 1'b0;
      repeat (10) @(negedge clk);
      check_counts("f2");

      // Frame 3: asynchronous reset once the window row reaches y=2.
      clear_counts();
      build_frame(128);
      pulse_start(sc);
      found = 0;
      for (int i = 0; i < 1000 && found == 0; i++) begin
         @(negedge clk);
         if (win_valid && win_y == CW'(2)) found = 1;
      end
      chk("f3_reached_y2", 32'(found), 32'd1);
      #2 rst = 1'b1;
      #1 check_all_zero("midreset");
      q_hs.delete();
      q_win.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clear_counts();

      // Frame 4: fresh buffer after reset restarts at x=y=0, addr 0.
      build_frame(0);
      pulse_start(sc);
      chk("f4_start_addr", 32'(buf_read_addr), 32'd0);
      wait_done(2000, dc);
      chk("f4_done_latency", 32'(dc - sc), 32'd353);
      repeat (3) @(negedge clk);
      check_counts("f4");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
